// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer.
// The trap_count feature is enabled by defining TRAP_COUNTER_EN.
package common_types_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      COMMIT,
      REDIRECT,
      MRET
   } trap_state_t;

   localparam logic [31:0] EXC_ILLEGAL_INST = 32'd2;
   localparam logic [1:0]  MTVEC_DIRECT     = 2'd0;
   localparam logic [1:0]  MTVEC_VECTORED   = 2'd1;

   // mcause layout: interrupt flag in bit 31, cause code in bits [4:0].
   function automatic logic [31:0] make_mcause(input logic intr, input logic [4:0] code);
      return {intr, 26'b0, code};
   endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of decode/execute, CSR-file and fetch-mux signals around the trap sequencer.
// The trap_count feature is enabled by defining TRAP_COUNTER_EN.
//
// Handshake: there is no backpressure. csr_trap_we, csr_mret_we and redirect_valid
// are single-cycle strobes; their data (trap_mepc, trap_mcause, redirect_pc) is valid
// only in the strobe cycle and reads 0 otherwise. Consumers must accept a strobe in
// the cycle it is presented.
interface trap_sequencer_if #(
   parameter int NUM_IRQ = 4
);
   logic               illegal_inst;
   logic [31:0]        e2mif_pc;
   logic [NUM_IRQ-1:0] irq_pending;
   logic [NUM_IRQ-1:0] irq_enable;
   logic               mstatus_mie;
   logic [1:0]         mtvec_mode;
   logic [31:0]        mtvec_base;
   logic               mret;
   logic [31:0]        mepc_in;
   logic               mem_busy;

   logic               f2dif_flush;
   logic               d2eif_flush;
   logic               e2mif_flush;
   logic               m2wif_flush;
   logic               csr_trap_we;
   logic               csr_mret_we;
   logic [31:0]        trap_mepc;
   logic [31:0]        trap_mcause;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               busy;
   logic [31:0]        trap_count;

   // Sequencer side.
   modport master (
      input  illegal_inst, e2mif_pc, irq_pending, irq_enable, mstatus_mie,
             mtvec_mode, mtvec_base, mret, mepc_in, mem_busy,
      output f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush,
             csr_trap_we, csr_mret_we, trap_mepc, trap_mcause,
             redirect_valid, redirect_pc, busy, trap_count
   );

   // Core / CSR-file side.
   modport slave (
      output illegal_inst, e2mif_pc, irq_pending, irq_enable, mstatus_mie,
             mtvec_mode, mtvec_base, mret, mepc_in, mem_busy,
      input  f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush,
             csr_trap_we, csr_mret_we, trap_mepc, trap_mcause,
             redirect_valid, redirect_pc, busy, trap_count
   );

endinterface

// File: rtl/trap_sequencer_irq_prio_enc.sv
// Lowest-index priority encoder over the enabled interrupt lines.
// The trap_count feature is enabled by defining TRAP_COUNTER_EN.
module irq_prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [4:0]   idx
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = 5'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 5'(i);
         end
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / mret sequencer: arbitrates exceptions against interrupts, flushes
// the pipeline, drains memory, commits CSR updates and redirects fetch.
// Define TRAP_COUNTER_EN to build the trap_count counter; otherwise it reads 0.
import common_types_pkg::*;

module trap_sequencer #(
   parameter int NUM_IRQ       = 4,
   parameter int MEM_DRAIN_MAX = 15
) (
   input  logic              CLK,
   input  logic              nRST,
   trap_sequencer_if.master  bus,
   output trap_state_t       dbg_state
);

   localparam int CW = $clog2(MEM_DRAIN_MAX + 1);
   // The counter reaches MEM_DRAIN_MAX on the same edge that forces the exit.
   localparam logic [CW-1:0] DRAIN_LAST = CW'(MEM_DRAIN_MAX - 1);

   trap_state_t   state, next_state;
   logic [31:0]   pc_q, pc_d;
   logic          intr_q, intr_d;
   logic [4:0]    code_q, code_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          irq_valid;
   logic [4:0]    irq_idx;

   logic          f2d, d2e, e2m, m2w;
   logic          trap_we, mret_we, rvalid;
   logic [31:0]   mepc_o, mcause_o, rpc_o;

   // Low address bits of mtvec/mepc are architecturally ignored.
   logic          unused_lsbs;
   assign unused_lsbs = &{1'b0, bus.mtvec_base[1:0], bus.mepc_in[1:0]};

   irq_prio_enc #(.N(NUM_IRQ)) u_irq_prio_enc (
      .req   (bus.irq_pending & bus.irq_enable),
      .valid (irq_valid),
      .idx   (irq_idx)
   );

   // State, latched trap source and drain counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         pc_q   <= '0;
         intr_q <= 1'b0;
         code_q <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= next_state;
         pc_q   <= pc_d;
         intr_q <= intr_d;
         code_q <= code_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next-state selection and per-state output strobes.
   always_comb begin
      next_state = state;
      pc_d       = pc_q;
      intr_d     = intr_q;
      code_d     = code_q;
      cnt_d      = cnt_q;
      f2d        = 1'b0;
      d2e        = 1'b0;
      e2m        = 1'b0;
      m2w        = 1'b0;
      trap_we    = 1'b0;
      mret_we    = 1'b0;
      rvalid     = 1'b0;
      mepc_o     = '0;
      mcause_o   = '0;
      rpc_o      = '0;
      case (state)
         IDLE: begin
            if (bus.illegal_inst) begin
               pc_d       = bus.e2mif_pc;
               intr_d     = 1'b0;
               code_d     = EXC_ILLEGAL_INST[4:0];
               cnt_d      = '0;
               next_state = DRAIN;
            end else if (bus.mstatus_mie && irq_valid) begin
               pc_d       = bus.e2mif_pc;
               intr_d     = 1'b1;
               code_d     = irq_idx;
               cnt_d      = '0;
               next_state = DRAIN;
            end else if (bus.mret) begin
               next_state = MRET;
            end
         end
         DRAIN: begin
            f2d   = 1'b1;
            d2e   = 1'b1;
            e2m   = 1'b1;
            m2w   = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (!bus.mem_busy || cnt_q == DRAIN_LAST) begin
               next_state = COMMIT;
            end
         end
         COMMIT: begin
            trap_we    = 1'b1;
            mepc_o     = pc_q;
            mcause_o   = make_mcause(intr_q, code_q);
            next_state = REDIRECT;
         end
         REDIRECT: begin
            rvalid = 1'b1;
            if (intr_q && bus.mtvec_mode == MTVEC_VECTORED) begin
               rpc_o = {bus.mtvec_base[31:2], 2'b00} + {25'd0, code_q, 2'b00};
            end else begin
               rpc_o = {bus.mtvec_base[31:2], 2'b00};
            end
            next_state = IDLE;
         end
         MRET: begin
            mret_we    = 1'b1;
            rvalid     = 1'b1;
            rpc_o      = {bus.mepc_in[31:2], 2'b00};
            f2d        = 1'b1;
            d2e        = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

`ifdef TRAP_COUNTER_EN
   logic [31:0] count_q;

   // Count committed traps; mret never passes through COMMIT.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else if (state == COMMIT) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign bus.trap_count = count_q;
`else
   assign bus.trap_count = 32'd0;
`endif

   assign bus.f2dif_flush    = f2d;
   assign bus.d2eif_flush    = d2e;
   assign bus.e2mif_flush    = e2m;
   assign bus.m2wif_flush    = m2w;
   assign bus.csr_trap_we    = trap_we;
   assign bus.csr_mret_we    = mret_we;
   assign bus.trap_mepc      = mepc_o;
   assign bus.trap_mcause    = mcause_o;
   assign bus.redirect_valid = rvalid;
   assign bus.redirect_pc    = rpc_o;
   assign bus.busy           = (state != IDLE);
   assign dbg_state          = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: per-cycle output words are compared with
// a transaction-level model of the trap/mret timeline.
// Build with TRAP_COUNTER_EN defined to also check the trap counter.
module tb_trap_sequencer;
   import common_types_pkg::*;

   localparam int W        = 136;
   localparam int DRAIN_MX = 15;
`ifdef TRAP_COUNTER_EN
   localparam bit COUNT_ON = 1'b1;
`else
   localparam bit COUNT_ON = 1'b0;
`endif

   logic        CLK;
   logic        nRST;
   trap_state_t dbg_state;

   trap_sequencer_if #(.NUM_IRQ(4)) bus ();

   trap_sequencer #(.NUM_IRQ(4), .MEM_DRAIN_MAX(DRAIN_MX)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   // Clock and reset.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] model_count = 32'd0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   function automatic logic [W-1:0] mk(input logic [3:0] fl, input logic twe, input logic mwe,
                                       input logic rv, input logic bsy, input logic [31:0] mepc,
                                       input logic [31:0] cause, input logic [31:0] rpc,
                                       input logic [31:0] cnt);
      return {fl, twe, mwe, rv, bsy, mepc, cause, rpc, cnt};
   endfunction

   function automatic logic [W-1:0] observe();
      return {bus.f2dif_flush, bus.d2eif_flush, bus.e2mif_flush, bus.m2wif_flush,
              bus.csr_trap_we, bus.csr_mret_we, bus.redirect_valid, bus.busy,
              bus.trap_mepc, bus.trap_mcause, bus.redirect_pc, bus.trap_count};
   endfunction

   function automatic logic [31:0] exp_cnt();
      return COUNT_ON ? model_count : 32'd0;
   endfunction

   // Reference model: what the outputs must look like on each cycle after a trigger.
   task automatic model_seq(input logic illegal, input logic [31:0] pc, input logic [3:0] pend,
                            input logic [3:0] en, input logic mie, input logic mret_in,
                            input logic [1:0] mode, input logic [31:0] base,
                            input logic [31:0] mepc, input int busy_n);
      logic [3:0]  live;
      int          code;
      logic        intr;
      int          drain_len;
      logic [31:0] tgt;
      exp_q.delete();
      live = pend & en;
      if (illegal || (mie && live != 4'd0)) begin
         if (illegal) begin
            intr = 1'b0;
            code = 2;
         end else begin
            intr = 1'b1;
            code = 0;
            while (((live >> code) & 4'd1) == 4'd0) code++;
         end
         drain_len = (busy_n < 1) ? 1 : ((busy_n > DRAIN_MX) ? DRAIN_MX : busy_n);
         tgt = (base & ~32'd3);
         if (intr && mode == 2'd1) tgt = tgt + 32'(code * 4);
         for (int j = 0; j < drain_len; j++)
            exp_q.push_back(mk(4'hF, 0, 0, 0, 1, 0, 0, 0, exp_cnt()));
         exp_q.push_back(mk(4'h0, 1, 0, 0, 1, pc, (intr ? 32'h8000_0000 : 32'd0) + 32'(code),
                            0, exp_cnt()));
         model_count = model_count + 32'd1;
         exp_q.push_back(mk(4'h0, 0, 0, 1, 1, 0, 0, tgt, exp_cnt()));
      end else if (mret_in) begin
         exp_q.push_back(mk(4'hC, 0, 1, 1, 1, 0, 0, mepc & ~32'd3, exp_cnt()));
      end
      exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, exp_cnt()));
      exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, exp_cnt()));
   endtask

   // Driver: present one trigger cycle, then record exp_q.size() cycles of outputs.
   task automatic drive_seq(input logic illegal, input logic [31:0] pc, input logic [3:0] pend,
                            input logic [3:0] en, input logic mie, input logic mret_in,
                            input logic [1:0] mode, input logic [31:0] base,
                            input logic [31:0] mepc, input int busy_n);
      obs_q.delete();
      @(negedge CLK);
      bus.illegal_inst = illegal;
      bus.e2mif_pc     = pc;
      bus.irq_pending  = pend;
      bus.irq_enable   = en;
      bus.mstatus_mie  = mie;
      bus.mret         = mret_in;
      bus.mtvec_mode   = mode;
      bus.mtvec_base   = base;
      bus.mepc_in      = mepc;
      bus.mem_busy     = (busy_n > 0);
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge CLK);
         bus.illegal_inst = 1'b0;
         bus.mret         = 1'b0;
         bus.irq_pending  = 4'd0;
         bus.mem_busy     = (c + 1 < busy_n);
         #1;
         obs_q.push_back(observe());
      end
   endtask

   task automatic txn(input logic illegal, input logic [31:0] pc, input logic [3:0] pend,
                      input logic [3:0] en, input logic mie, input logic mret_in,
                      input logic [1:0] mode, input logic [31:0] base,
                      input logic [31:0] mepc, input int busy_n);
      model_seq(illegal, pc, pend, en, mie, mret_in, mode, base, mepc, busy_n);
      drive_seq(illegal, pc, pend, en, mie, mret_in, mode, base, mepc, busy_n);
   endtask

   task automatic test_reset();
      nRST             = 1'b0;
      bus.illegal_inst = 1'b0;
      bus.e2mif_pc     = 32'd0;
      bus.irq_pending  = 4'd0;
      bus.irq_enable   = 4'd0;
      bus.mstatus_mie  = 1'b0;
      bus.mtvec_mode   = 2'd0;
      bus.mtvec_base   = 32'd0;
      bus.mret         = 1'b0;
      bus.mepc_in      = 32'd0;
      bus.mem_busy     = 1'b0;
      repeat (3) @(negedge CLK);
      vectors++;
      if (observe() !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected %h", observe(), {W{1'b0}});
      end
      vectors++;
      if (dbg_state !== IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      nRST = 1'b1;
      model_count = 32'd0;
   endtask

   task automatic test_illegal();
      txn(1, 32'h100, 4'h0, 4'h0, 0, 0, 2'd0, 32'h8000, 32'd0, 0);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL illegal cycle %0d: got %h expected %h", i + 1, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_vectored_irq();
      for (int m = 0; m < 3; m++) begin
         txn(0, 32'h444, 4'b1010, 4'b1110, 1, 0, 2'(m), 32'h8001, 32'd0, 0);
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL irq_mode%0d cycle %0d: got %h expected %h", m, i + 1,
                        obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      txn(1, 32'h2468, 4'b0001, 4'b0001, 1, 1, 2'd1, 32'h4000, 32'h300, 0);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL simultaneous cycle %0d: got %h expected %h", i + 1, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_drain();
      int lens[3] = '{5, 40, 15};
      foreach (lens[k]) begin
         txn(0, 32'h1000 + 32'(k), 4'b0100, 4'b0100, 1, 0, 2'd1, 32'hC000, 32'd0, lens[k]);
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL drain_busy%0d cycle %0d: got %h expected %h", lens[k], i + 1,
                        obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_mret();
      txn(0, 32'h0, 4'b0010, 4'b0010, 0, 1, 2'd0, 32'h8000, 32'h203, 0);
      foreach (exp_q[i]) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL mret cycle %0d: got %h expected %h", i + 1, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         txn($urandom_range(0, 3) == 0, $urandom, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 20));
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL random%0d cycle %0d: got %h expected %h", t, i + 1,
                        obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      bus.illegal_inst = 1'b1;
      bus.e2mif_pc     = 32'h600;
      bus.mtvec_base   = 32'h9000;
      bus.mem_busy     = 1'b0;
      @(negedge CLK);
      bus.illegal_inst = 1'b0;
      @(negedge CLK);
      #1;
      vectors++;
      if (bus.csr_trap_we !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_commit: got %b expected 1", bus.csr_trap_we);
      end
      nRST = 1'b0;
      #1;
      vectors++;
      if (observe() !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_abort: got %h expected %h", observe(), {W{1'b0}});
      end
      model_count = 32'd0;
      @(negedge CLK);
      nRST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         #1;
         vectors++;
         if (observe() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet cycle %0d: got %h expected %h", c, observe(),
                     {W{1'b0}});
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 3; t++) begin
         txn(0, 32'h700 + 32'(t * 4), 4'b1000, 4'b1000, 1, 0, 2'd1, 32'hA000, 32'd0, t);
         foreach (exp_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL back_to_back%0d cycle %0d: got %h expected %h", t, i + 1,
                        obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_vectored_irq();
      test_simultaneous();
      test_drain();
      test_mret();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
